bcd_serial_converter: RTL
=========================

// Module: bcd_serial_converter
//
// PURPOSE
//   Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that
//   feeds the four-digit seven-segment display stage. On a start pulse it
//   captures a WIDTH-bit unsigned value and takes WIDTH shift cycles to convert it.
//   It then presents four registered BCD digits plus a one-cycle done pulse.
//   Digits hold between conversions, so the display sees glitch-free values.
//
// PARAMETERS
//   WIDTH   13   binary input width; legal range 1..13 (2^WIDTH-1 <= 9999);
//                an elaboration-time check rejects WIDTH > 13
//
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   rst_n      in   1      synchronous reset, active-low
//   start      in   1      request conversion; sampled only when busy==0
//   bin        in   WIDTH  unsigned binary value, captured on accepted start
//   busy       out  1      conversion in progress
//   done       out  1      one-cycle pulse: new digits valid this cycle
//   valid      out  1      at least one conversion has completed since reset
//   thousands  out  4      BCD digit 3 (MSD), registered
//   hundreds   out  4      BCD digit 2, registered
//   tens       out  4      BCD digit 1, registered
//   ones       out  4      BCD digit 0 (LSD), registered
//
// BEHAVIOUR
//   - Reset (rst_n==0 at a rising edge):
//     - State returns to IDLE; the shift counter and the scratch register clear.
//     - busy=0, done=0, valid=0 and all four digits are 0.
//   - FSM states and transitions:
//     - IDLE: if start=1, go to SHIFT, else stay in IDLE.
//     - SHIFT: after WIDTH shift cycles, go to IDLE. There is no separate DONE state.
//   - Accept (edge E, state IDLE, start=1):
//     - Capture bin into the binary shift register and clear the 16-bit BCD scratch.
//     - Set the counter to 0 and busy to 1.
//   - Each SHIFT edge (E+1 .. E+WIDTH):
//     - Any scratch nibble >= 5 first gets +3 (4-bit, no carry out of the nibble).
//     - The {scratch, binary} register then shifts left by 1, MSB of binary into scratch bit 0.
//     - The counter then increments.
//   - Final shift (edge E+WIDTH):
//     - The shifted scratch is written straight into thousands..ones.
//     - done=1 and valid=1 are set, busy=0, and the state returns to IDLE.
//     - done is high for exactly one cycle (E+WIDTH .. E+WIDTH+1).
//   - Latency and throughput:
//     - Start edge to done/digits is WIDTH edges (13 at the default).
//     - Maximum throughput is one conversion per WIDTH+1 cycles.
//   - start while busy=1: ignored, with no queueing and no effect on the current conversion.
//   - start high in the cycle done=1: accepted, since the state is IDLE.
//     - Back-to-back conversions are allowed.
//     - The digits keep the old result until the new conversion's final edge.
//   - Changes on bin after the accept edge: ignored.
//   - start held high continuously: the block converts repeatedly, every WIDTH+1 cycles.
//   - Reset mid-conversion: abort immediately.
//     - No done pulse; the digits and valid clear to 0.
//   - Digits never change except on a final-shift edge or on reset.
//   - Each digit is always in 0..9.
//   - Unused upper digits read 0 (e.g. thousands=0 when WIDTH <= 9).
//
// TESTING
//   1. Hold rst_n=0 for 3 cycles
//      -> busy=0, done=0, valid=0, all digits 0.
//   2. Start with bin=8191 at edge E
//      -> busy=1 over E..E+12; done=1 only at E+13; digits 8,1,9,1; valid=1.
//   3. Start with bin=1234; assert start with bin=905 in the done cycle
//      -> digits 1,2,3,4 for 14 cycles, then 0,9,0,5; two done pulses 14 cycles apart.
//   4. Start with bin=42, then pulse start with bin=7777 at E+4 and change bin at E+6
//      -> one done pulse only; digits 0,0,4,2.
//   5. Start with bin=5000, drive rst_n=0 at E+5, release and wait 20 cycles
//      -> no done pulse; digits 0; valid=0.
//   6. Exhaustive sweep of bin=0..8191, back-to-back
//      -> each result equals bin/1000, (bin/100)%10, (bin/10)%10, bin%10.

Source files
------------

// File: rtl/bcd_serial_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3) feeding the 7-seg display stage.
// Ports: clk, rst_n (sync, active-low), start/bin in; busy, done, valid, thousands..ones out.
// Latency WIDTH edges from accepted start to done; start ignored while busy (no queueing).
module bcd_serial_converter #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic [3:0]       thousands,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  // Four BCD digits can hold at most 9999, so 13 bits is the widest legal input.
  if (WIDTH < 1 || WIDTH > 13) begin : g_bad_width
    $error("bcd_serial_converter: WIDTH must be in 1..13");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [15:0]      scratch;
  logic [WIDTH-1:0] bin_sr;
  logic [15:0]      adj;
  logic [15:0]      shifted;
  logic             last;

  always_comb begin
    adj       = scratch;
    shifted   = 16'd0;
    last      = 1'b0;
    state_nxt = state;

    // Correct every nibble before the shift so it cannot exceed 9 after doubling.
    for (int i = 0; i < 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    shifted = {adj[14:0], bin_sr[WIDTH-1]};
    last    = (cnt == 4'(WIDTH - 1));

    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      scratch   <= 16'd0;
      bin_sr    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid     <= 1'b0;
      thousands <= 4'd0;
      hundreds  <= 4'd0;
      tens      <= 4'd0;
      ones      <= 4'd0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            scratch <= 16'd0;
            cnt     <= 4'd0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          bin_sr  <= bin_sr << 1;
          cnt     <= cnt + 4'd1;
          if (last) begin
            // The final shifted value goes straight to the digit registers.
            thousands <= shifted[15:12];
            hundreds  <= shifted[11:8];
            tens      <= shifted[7:4];
            ones      <= shifted[3:0];
            done      <= 1'b1;
            valid     <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
